// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM encoding,
// instruction field positions and flag bit indices.
package alu_ctrl_pkg;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int IW   = 10;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_PASSA = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_SHR   = 3'b110;
  localparam logic [2:0] OP_ZERO  = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;

  localparam int INSTR_WB_EN   = 9;
  localparam int INSTR_OP_MSB  = 8;
  localparam int INSTR_OP_LSB  = 6;
  localparam int INSTR_RD_MSB  = 5;
  localparam int INSTR_RD_LSB  = 4;
  localparam int INSTR_RS1_MSB = 3;
  localparam int INSTR_RS1_LSB = 2;
  localparam int INSTR_RS2_MSB = 1;
  localparam int INSTR_RS2_LSB = 0;

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_OVER  = 0;

  typedef struct packed {
    logic       wb_en;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

  function automatic instr_t decode_instr(input logic [IW-1:0] word);
    instr_t d;
    d.wb_en = word[INSTR_WB_EN];
    d.op    = word[INSTR_OP_MSB:INSTR_OP_LSB];
    d.rd    = word[INSTR_RD_MSB:INSTR_RD_LSB];
    d.rs1   = word[INSTR_RS1_MSB:INSTR_RS1_LSB];
    d.rs2   = word[INSTR_RS2_MSB:INSTR_RS2_LSB];
    return d;
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// Small register file: two operand read ports and one debug read port, all
// combinational, plus a single synchronous write port with synchronous clear.
module regfile4x8
  import alu_ctrl_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Three-state execute loop around the combinational ALU: accept an
// instruction, read operands, drive the ALU for one cycle, write back.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [9:0]    instr,
  output logic          instr_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic          alu_zero,
  input  logic          alu_neg,
  input  logic          alu_over,
  output logic [3:0]    flags,
  output logic          done,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [1:0]    state;
  instr_t        ir;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          in_idle;
  logic          in_exec;

  assign in_idle     = (state == IDLE);
  assign in_exec     = (state == EXEC);
  assign instr_ready = rst_n & ~ld_valid & in_idle;

  // The single write port is shared: loads only land in IDLE, writeback only in EXEC.
  assign rf_we    = (in_idle & ld_valid) | (in_exec & ir.wb_en);
  assign rf_waddr = in_exec ? AW'(ir.rd) : ld_addr;
  assign rf_wdata = in_exec ? ((ir.op == OP_ZERO) ? '0 : alu_out) : ld_data;

  assign alu_a   = in_exec ? opa : '0;
  assign alu_b   = in_exec ? opb : '0;
  assign alu_sel = in_exec ? ir.op : 3'b000;

  regfile4x8 #(.DW(DW), .NREG(NREG), .AW(AW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .rs1_addr (AW'(ir.rs1)),
    .rs2_addr (AW'(ir.rs2)),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
      opa   <= '0;
      opb   <= '0;
      flags <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            ir    <= decode_instr(instr);
            state <= READ;
          end
        end
        READ: begin
          opa   <= rs1_data;
          opb   <= rs2_data;
          state <= EXEC;
        end
        EXEC: begin
          flags[FLAG_CARRY] <= alu_carry;
          flags[FLAG_ZERO]  <= alu_zero;
          flags[FLAG_NEG]   <= alu_neg;
          flags[FLAG_OVER]  <= alu_over;
          done              <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a reference ALU drives the DUT's
// ALU inputs and a transaction-level model predicts every observable output.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [9:0] instr;
  logic       instr_ready;
  logic       ld_valid;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       alu_carry, alu_zero, alu_neg, alu_over;
  logic [3:0] flags;
  logic       done;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [11:0] alu_res;

  int checks;
  int failures;
  int done_pulses;
  bit cmp_en;

  // Model state: register contents, flags, and how far the one in-flight instruction has got.
  logic [7:0] m_regs [4];
  logic [3:0] m_flags;
  logic       m_done;
  int         m_busy;
  logic       p_wb;
  logic [1:0] p_rd;
  logic [2:0] p_op;
  logic [7:0] p_a, p_b, p_res;
  logic [3:0] p_flags;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .alu_over    (alu_over),
    .flags       (flags),
    .done        (done),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {carry, zero, neg, over, result}.
  function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (op)
      3'b000: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'b001: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a;
      3'b101: begin r = {a[6:0], 1'b0}; c = a[7]; end
      3'b110: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r[7], v, r};
  endfunction

  assign alu_res = alu_model(alu_sel, alu_a, alu_b);
  assign {alu_carry, alu_zero, alu_neg, alu_over, alu_out} = alu_res;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [1:0] la, input logic [7:0] ld,
                               input logic iv, input logic [9:0] ins);
    ld_valid    = lv;
    ld_addr     = la;
    ld_data     = ld;
    instr_valid = iv;
    instr       = ins;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dbg_addr = dbg_addr + 2'd1;
  endtask

  task automatic peekReg(input logic [1:0] addr, input logic [7:0] expected, input string name);
    dbg_addr = addr;
    #1;
    checkOutput(name, 32'(dbg_data), 32'(expected));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 10'd0);
  endtask

  // Transaction-level model, advanced on each rising edge from the inputs alone.
  initial begin
    m_busy = 0;
    m_done = 1'b0;
    m_flags = 4'h0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 4'h0;
        m_busy  = 0;
        m_done  = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_busy == 2) begin
          if (p_wb) m_regs[p_rd] = p_res;
          m_flags = p_flags;
          m_done  = 1'b1;
          m_busy  = 0;
        end else if (m_busy == 1) begin
          m_busy = 2;
        end else if (ld_valid) begin
          m_regs[ld_addr] = ld_data;
        end else if (instr_valid) begin
          logic [11:0] r;
          p_wb    = instr[9];
          p_op    = instr[8:6];
          p_rd    = instr[5:4];
          p_a     = m_regs[instr[3:2]];
          p_b     = m_regs[instr[1:0]];
          r       = alu_model(p_op, p_a, p_b);
          p_res   = (p_op == 3'b111) ? 8'h00 : r[7:0];
          p_flags = r[11:8];
          m_busy  = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checkOutput("instr_ready", 32'(instr_ready), 32'(rst_n && (m_busy == 0) && !ld_valid));
        checkOutput("done", 32'(done), 32'(m_done));
        checkOutput("flags", 32'(flags), 32'(m_flags));
        checkOutput("alu_a", 32'(alu_a), 32'((m_busy == 2) ? p_a : 8'h00));
        checkOutput("alu_b", 32'(alu_b), 32'((m_busy == 2) ? p_b : 8'h00));
        checkOutput("alu_sel", 32'(alu_sel), 32'((m_busy == 2) ? p_op : 3'b000));
        checkOutput("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
        if (done) done_pulses++;
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    done_pulses = 0;
    cmp_en = 1'b0;
    rst_n = 1'b0;
    dbg_addr = 2'd0;
    idle();

    tick();
    cmp_en = 1'b1;
    checkOutput("ready_in_reset", 32'(instr_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", 32'(instr_ready), 32'd1);
    checkOutput("flags_after_reset", 32'(flags), 32'd0);
    checkOutput("done_after_reset", 32'(done), 32'd0);

    // r0 = r1 + r2 with 5 + 3
    applyStimulus(1'b1, 2'd1, 8'h05, 1'b0, 10'd0); tick();
    applyStimulus(1'b1, 2'd2, 8'h03, 1'b0, 10'd0); tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 10'b1_000_00_01_10); tick();
    idle(); tick();
    checkOutput("add_done_early", 32'(done), 32'd0);
    tick();
    checkOutput("add_done", 32'(done), 32'd1);
    peekReg(2'd0, 8'h08, "add_r0");
    checkOutput("add_flags", 32'(flags), 32'b0000);

    // r3 = 0xFF + 0x01 wraps to zero with carry
    applyStimulus(1'b1, 2'd1, 8'hFF, 1'b0, 10'd0); tick();
    applyStimulus(1'b1, 2'd2, 8'h01, 1'b0, 10'd0); tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 10'b1_000_11_01_10); tick();
    idle(); tick(); tick();
    peekReg(2'd3, 8'h00, "wrap_r3");
    checkOutput("wrap_flags", 32'(flags), 32'b1100);

    // compare-only SUB r1 - r1
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 10'b0_001_00_01_01); tick();
    idle(); tick(); tick();
    checkOutput("cmp_flags", 32'(flags), 32'b0100);
    peekReg(2'd1, 8'hFF, "cmp_r1_kept");
    peekReg(2'd0, 8'h08, "cmp_r0_kept");

    // load and instruction in the same cycle: load wins, instruction waits
    applyStimulus(1'b1, 2'd2, 8'hAA, 1'b1, 10'b1_011_00_10_01);
    #1;
    checkOutput("ld_blocks_ready", 32'(instr_ready), 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 10'b1_011_00_10_01);
    #1;
    checkOutput("ready_after_ld", 32'(instr_ready), 32'd1);
    tick();
    idle(); tick(); tick();
    peekReg(2'd0, 8'hFF, "or_r0");
    peekReg(2'd2, 8'hAA, "or_r2");
    checkOutput("or_flags", 32'(flags), 32'b0010);

    // reset during EXEC of r0 = 0x80 >> 1 aborts everything
    applyStimulus(1'b1, 2'd0, 8'h80, 1'b0, 10'd0); tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 10'b1_110_00_00_00); tick();
    idle(); tick();
    rst_n = 1'b0;
    tick();
    checkOutput("abort_done", 32'(done), 32'd0);
    peekReg(2'd0, 8'h00, "abort_r0");
    peekReg(2'd1, 8'h00, "abort_r1");
    rst_n = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(instr_ready), 32'd1);
    tick();
    peekReg(2'd2, 8'h00, "abort_r2");
    peekReg(2'd3, 8'h00, "abort_r3");
    checkOutput("abort_flags", 32'(flags), 32'd0);
    checkOutput("abort_no_done", 32'(done), 32'd0);

    // three back-to-back dependent instructions: r1 += r2 with r1=1, r2=2
    applyStimulus(1'b1, 2'd1, 8'h01, 1'b0, 10'd0); tick();
    applyStimulus(1'b1, 2'd2, 8'h02, 1'b0, 10'd0); tick();
    done_pulses = 0;
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 10'b1_000_01_01_10);
    repeat (7) tick();
    idle();
    repeat (4) tick();
    checkOutput("stream_done_pulses", 32'(done_pulses), 32'd3);
    peekReg(2'd1, 8'h07, "stream_r1");
    checkOutput("stream_flags", 32'(flags), 32'b0000);

    // opcode 111 clears rd even though operands are non-zero
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 10'b1_111_10_01_01); tick();
    idle(); tick(); tick();
    peekReg(2'd2, 8'h00, "zero_r2");
    checkOutput("zero_flags", 32'(flags), 32'b0100);
    tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
